// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, in-order imem requests, prefetch FIFO to decode.
// Define FETCH_PERF_EN to add the perf_fetch_count / perf_flush_count counters.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_count,
    output logic [31:0]       perf_flush_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic              run;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     drop;
    logic [CW:0]       credit_sum;

    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [31:0]       fifo_instr [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    // Addresses of accepted, still-live requests; popped only by kept responses.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PW-1:0]     aq_rd;
    logic [PW-1:0]     aq_wr;

    logic req_fire;
    logic push;
    logic pop;

    // Stale requests still hold credit until they return, so the FIFO never overflows.
    assign credit_sum     = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = run & ~redirect_valid & (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;

    assign instr_valid = (count != '0) & ~redirect_valid;
    assign instr_out   = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    assign req_fire = imem_req_valid & imem_req_ready;
    assign push     = imem_rsp_valid & (drop == '0) & ~redirect_valid;
    assign pop      = instr_valid & instr_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    // NOTE: state uses non-blocking assignments so every term above reads pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            run         <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge is stale.
                pc     <= redirect_target & ~ADDR_W'(3);
                drop   <= outstanding_next;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                aq_rd  <= '0;
                aq_wr  <= '0;
            end else begin
                if (req_fire) begin
                    pc    <= pc + ADDR_W'(4);
                    aq_wr <= aq_wr + PW'(1);
                end
                if (imem_rsp_valid && drop != '0) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    aq_rd  <= aq_rd + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays have no reset; count and the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q[aq_wr] <= pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= addr_q[aq_rd];
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_count <= '0;
            perf_flush_count <= '0;
        end else begin
            if (pop) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model and a queue-based reference
// model compared every cycle, plus literal expectations at the scenario boundaries.
module tb_fetch_unit;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_flush_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_count(perf_fetch_count),
        .perf_flush_count(perf_flush_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Reference model: decode-visible queue, in-flight requests with stale flags, next PC.
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic stale; logic [31:0] pc; } flight_t;
    typedef struct { int due; logic [31:0] addr; } mreq_t;

    entry_t      m_q[$];
    flight_t     m_fl[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_run = 1'b0;
    int          m_fetch = 0;
    int          m_flush = 0;

    mreq_t mem_q[$];
    int    mem_lat = 1;
    int    cyc = 0;

    logic        s_req_valid, s_instr_valid;
    logic [31:0] s_req_addr, s_instr_pc, s_instr_out;

    function automatic void model_reset();
        m_q.delete();
        m_fl.delete();
        mem_q.delete();
        m_pc    = RESET_PC;
        m_run   = 1'b0;
        m_fetch = 0;
        m_flush = 0;
    endfunction

    // One clock cycle: entered and left at the falling edge, with this cycle's inputs already set.
    task automatic cycle();
        bit      e_req, e_iv, rsp;
        flight_t f;
        if (!reset_n) model_reset();
        if (reset_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        e_req = m_run && !redirect_valid && (m_q.size() + m_fl.size() < DEPTH);
        e_iv  = (m_q.size() > 0) && !redirect_valid;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_pc    = instr_pc;
        s_instr_out   = instr_out;
        check_bit("req_valid", imem_req_valid, e_req);
        check("req_addr", imem_req_addr, m_pc);
        check_bit("instr_valid", instr_valid, e_iv);
        if (e_iv) begin
            check("instr_pc", instr_pc, m_q[0].pc);
            check("instr_out", instr_out, m_q[0].data);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_count, m_fetch);
        check("perf_flush", perf_flush_count, m_flush);
`endif
        rsp = imem_rsp_valid;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (rsp) begin
                void'(mem_q.pop_front());
                if (m_fl.size() > 0) begin
                    f = m_fl.pop_front();
                    if (!f.stale && !redirect_valid) m_q.push_back('{f.pc, data_of(f.pc)});
                end
            end
            if (redirect_valid) begin
                m_flush++;
                m_q.delete();
                foreach (m_fl[i]) m_fl[i].stale = 1'b1;
                m_pc = redirect_target & ~32'h3;
            end else begin
                if (e_iv && instr_ready) begin
                    void'(m_q.pop_front());
                    m_fetch++;
                end
                if (e_req && imem_req_ready) begin
                    m_fl.push_back('{1'b0, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1'b1;
            if (s_req_valid && imem_req_ready) mem_q.push_back('{cyc + mem_lat, s_req_addr});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;
        imem_req_ready  = 1'b1;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  found, got_req, wrap_armed;
        @(negedge clk);

        // Zero-wait memory, decode always ready.
        mem_lat = 1;
        do_reset();
        check_bit("s1_reset_req_valid", s_req_valid, 1'b0);
        check_bit("s1_reset_instr_valid", s_instr_valid, 1'b0);
        check("s1_reset_addr", s_req_addr, RESET_PC);
        instr_ready = 1'b1;
        cycle(); check_bit("s1_c0_req_valid", s_req_valid, 1'b0);
        cycle(); check_bit("s1_c1_req_valid", s_req_valid, 1'b1); check("s1_c1_addr", s_req_addr, 32'h0);
        cycle(); check("s1_c2_addr", s_req_addr, 32'h4); check_bit("s1_c2_instr_valid", s_instr_valid, 1'b0);
        cycle();
        check_bit("s1_c3_instr_valid", s_instr_valid, 1'b1);
        check("s1_c3_instr_pc", s_instr_pc, 32'h0);
        check("s1_c3_instr_out", s_instr_out, 32'hC0DE_0000);
        cycle();
        check("s1_c4_instr_pc", s_instr_pc, 32'h4);
        check("s1_c4_instr_out", s_instr_out, 32'hB803_E6C4);
        check("s1_c4_addr", s_req_addr, 32'h8);
        repeat (20) cycle();

        // Decode stalled: credit limits acceptance to DEPTH, then drains in order.
        do_reset();
        n = 0;
        repeat (10) begin
            cycle();
            if (s_req_valid && imem_req_ready) n++;
        end
        check("s2_accepted", n, 2);
        check_bit("s2_req_stalled", s_req_valid, 1'b0);
        check("s2_head_pc", s_instr_pc, 32'h0);
        instr_ready = 1'b1;
        cycle(); check("s2_drain0_pc", s_instr_pc, 32'h0);
        cycle();
        check("s2_drain1_pc", s_instr_pc, 32'h4);
        check_bit("s2_resume_valid", s_req_valid, 1'b1);
        check("s2_resume_addr", s_req_addr, 32'h8);
        repeat (10) cycle();

        // Redirect with two requests outstanding; unaligned target.
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        n = 0;
        repeat (3) begin
            cycle();
            if (s_req_valid && imem_req_ready) n++;
        end
        check("s3_outstanding", n, 2);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_1003;
        cycle(); check_bit("s3_redir_req_valid", s_req_valid, 1'b0);
        redirect_valid = 1'b0;
        found = 1'b0; got_req = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (!got_req && s_req_valid) begin
                got_req = 1'b1;
                check("s3_first_req_addr", s_req_addr, 32'h0000_1000);
            end
            if (s_instr_valid) begin
                found = 1'b1;
                check("s3_first_instr_pc", s_instr_pc, 32'h0000_1000);
            end
        end
        check_bit("s3_instr_seen", found, 1'b1);
        mem_lat = 1;
        repeat (10) cycle();

        // Redirect while an instruction is being handed over.
        for (int i = 0; i < 20 && m_q.size() == 0; i++) cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2000;
        cycle(); check_bit("s4_valid_masked", s_instr_valid, 1'b0);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_instr_valid) begin
                found = 1'b1;
                check("s4_next_pc", s_instr_pc, 32'h0000_2000);
            end
        end
        check_bit("s4_instr_seen", found, 1'b1);

        // PC wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        found = 1'b0; wrap_armed = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_req_valid) begin
                if (wrap_armed) begin
                    found = 1'b1;
                    check("s5_wrap_addr", s_req_addr, 32'h0);
                end else begin
                    check("s5_top_addr", s_req_addr, 32'hFFFF_FFFC);
                    wrap_armed = 1'b1;
                end
            end
        end
        check_bit("s5_wrap_seen", found, 1'b1);
        repeat (8) cycle();

        // Reset asserted mid-stream with responses in flight.
        mem_lat = 2;
        repeat (5) cycle();
        reset_n = 1'b0;
        cycle();
        check_bit("s6_rst_req_valid", s_req_valid, 1'b0);
        check_bit("s6_rst_instr_valid", s_instr_valid, 1'b0);
        check("s6_rst_addr", s_req_addr, RESET_PC);
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_instr_valid) begin
                found = 1'b1;
                check("s6_first_pc", s_instr_pc, RESET_PC);
            end
        end
        check_bit("s6_instr_seen", found, 1'b1);

        // Back-to-back redirects, the second landing on a stale response; then 10 handshakes.
        mem_lat = 2;
        do_reset();
        instr_ready = 1'b1;
        repeat (3) cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        cycle();
        redirect_target = 32'h0000_0400;
        cycle();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && m_fetch < 10; i++) begin
            cycle();
            if (!found && s_instr_valid) begin
                found = 1'b1;
                check("s7_first_pc", s_instr_pc, 32'h0000_0400);
            end
        end
        check("s7_handshakes", m_fetch, 10);
`ifdef FETCH_PERF_EN
        check("s7_perf_fetch", perf_fetch_count, 32'd10);
        check("s7_perf_flush", perf_flush_count, 32'd2);
`endif
        repeat (5) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
